// File: rtl/miner_pkg.sv
// Shared types and helpers for the miner host link.
//   link_state_e : link controller FSM states
//   NONCE_BYTES  : width of the little-endian nonce at the tail of the header
//   beat_count() : number of bus beats needed to move a byte count over a bus
package miner_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitAck,
        StWaitDig,
        StUnload
    } link_state_e;

    localparam int unsigned NONCE_BYTES = 4;

    function automatic int unsigned beat_count(input int unsigned num_bytes,
                                               input int unsigned bus_w);
        return (num_bytes * 8) / bus_w;
    endfunction

endpackage

// File: rtl/rdy_sync_edge.sv
// Synchroniser plus rising-edge detector for the asynchronous host beat strobe.
// Ports:
//   clk_i      core clock
//   rst_ni     asynchronous active-low reset
//   rdy_i      asynchronous host strobe
//   rdy_evt_o  one-cycle pulse per synchronised rising edge of rdy_i
module rdy_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rdy_i,
    output logic rdy_evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rdy_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rdy_evt_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hdr_link_ctrl.sv
// Host-side byte-serial link: loads a block header beat by beat over the rq/rdy
// handshake, offers it to the hash core, then streams the digest back to the host.
// Optional feature macro: BITCOIN_NONCE_SWEEP_EN (on-chip nonce increment from IDLE).
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             begin a header load (ignored outside IDLE)
//   rdy_i               asynchronous host beat strobe, rising edge = one beat
//   din_i / dout_o      header beat in / digest beat out (BUS_W bits)
//   rq_o                link requests a beat
//   done_o              high for the whole digest unload
//   busy_o              FSM not idle
//   hdr_data_o          assembled header, first beat in MSBs
//   hdr_valid_o/ack_i   header handshake to the core
//   dig_data_i/valid_i  digest from the core, first beat out = MSBs
//   nonce_inc_i         nonce sweep request
module hdr_link_ctrl
    import miner_pkg::*;
#(
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned HDR_BYTES   = 80,
    parameter int unsigned DIG_BYTES   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   rdy_i,
    input  logic [BUS_W-1:0]       din_i,
    output logic [BUS_W-1:0]       dout_o,
    output logic                   rq_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic [HDR_BYTES*8-1:0] hdr_data_o,
    output logic                   hdr_valid_o,
    input  logic                   hdr_ack_i,
    input  logic [DIG_BYTES*8-1:0] dig_data_i,
    input  logic                   dig_valid_i,
    input  logic                   nonce_inc_i
);

    localparam int unsigned HDR_W     = HDR_BYTES * 8;
    localparam int unsigned DIG_W     = DIG_BYTES * 8;
    localparam int unsigned HDR_BEATS = beat_count(HDR_BYTES, BUS_W);
    localparam int unsigned DIG_BEATS = beat_count(DIG_BYTES, BUS_W);
    localparam int unsigned MAX_BEATS = (HDR_BEATS > DIG_BEATS) ? HDR_BEATS : DIG_BEATS;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BEATS - 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_BEATS - 1);

    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rq_q, rq_d;
    logic             done_q, done_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             rdy_evt;
    logic             beat_evt;

    rdy_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rdy_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rdy_i    (rdy_i),
        .rdy_evt_o(rdy_evt)
    );

    // A strobe only counts while a beat is actually requested.
    assign beat_evt = rdy_evt & rq_q;

`ifdef BITCOIN_NONCE_SWEEP_EN
    localparam int unsigned NONCE_W = NONCE_BYTES * 8;

    logic hdr_loaded_q;

    // The nonce is little-endian in stream order: the first nonce byte on the
    // bus (highest bits of the field) is the least significant.
    function automatic logic [NONCE_W-1:0] bump_le(input logic [NONCE_W-1:0] field);
        logic [NONCE_W-1:0] val;
        logic [NONCE_W-1:0] res;
        for (int i = 0; i < int'(NONCE_BYTES); i++) begin
            val[i*8 +: 8] = field[NONCE_W-8-i*8 +: 8];
        end
        val = val + NONCE_W'(1);
        for (int i = 0; i < int'(NONCE_BYTES); i++) begin
            res[NONCE_W-8-i*8 +: 8] = val[i*8 +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_loaded_q <= 1'b0;
        end else if (state_q == StLoad && state_d == StWaitAck) begin
            hdr_loaded_q <= 1'b1;
        end
    end
`else
    logic unused_nonce_inc;
    assign unused_nonce_inc = nonce_inc_i;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rq_d        = rq_q;
        done_d      = done_q;
        hdr_valid_d = hdr_valid_q;
        hdr_d       = hdr_q;
        dig_d       = dig_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    rq_d    = 1'b1;
                    cnt_d   = '0;
                end
`ifdef BITCOIN_NONCE_SWEEP_EN
                else if (nonce_inc_i && hdr_loaded_q) begin
                    hdr_d[NONCE_W-1:0] = bump_le(hdr_q[NONCE_W-1:0]);
                    state_d            = StWaitAck;
                    hdr_valid_d        = 1'b1;
                end
`endif
            end
            StLoad: begin
                if (beat_evt) begin
                    for (int unsigned b = 0; b < HDR_BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            hdr_d[HDR_W-1-b*BUS_W -: BUS_W] = din_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    rq_d  = 1'b0;
                    if (cnt_q == HDR_LAST) begin
                        state_d     = StWaitAck;
                        hdr_valid_d = 1'b1;
                    end
                end else if (!rq_q) begin
                    // rq stays low for exactly one cycle so the host sees a new edge.
                    rq_d = 1'b1;
                end
            end
            StWaitAck: begin
                if (hdr_ack_i) begin
                    hdr_valid_d = 1'b0;
                    state_d     = StWaitDig;
                end
            end
            StWaitDig: begin
                if (dig_valid_i) begin
                    dig_d   = dig_data_i;
                    state_d = StUnload;
                    done_d  = 1'b1;
                    rq_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            StUnload: begin
                if (beat_evt) begin
                    rq_d  = 1'b0;
                    dig_d = dig_q << BUS_W;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == DIG_LAST) begin
                        done_d  = 1'b0;
                        state_d = StIdle;
                    end
                end else if (!rq_q) begin
                    rq_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rq_q        <= 1'b0;
            done_q      <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_q       <= '0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rq_q        <= rq_d;
            done_q      <= done_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_q       <= hdr_d;
            dig_q       <= dig_d;
        end
    end

    assign dout_o      = dig_q[DIG_W-1 -: BUS_W];
    assign rq_o        = rq_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != StIdle);
    assign hdr_data_o  = hdr_q;
    assign hdr_valid_o = hdr_valid_q;

endmodule

// File: tb/tb_hdr_link_ctrl.sv
// Bench for hdr_link_ctrl: an 8-bit and a 32-bit instance share clock and reset.
module tb_hdr_link_ctrl;

    localparam int SYNC = 2;

    localparam logic [639:0] GENESIS = {
        32'h01000000,
        256'h0,
        256'h3BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA4B1E5E4A,
        32'h29AB5F49, 32'hFFFF001D, 32'h1DAC2B7C
    };
    localparam logic [255:0] DIGEST =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [639:0] WRAPHDR = {GENESIS[639:32], 32'hFFFFFFFF};
    localparam logic [7:0]  PIN8 [8]  = '{8'h00, 8'h00, 8'h00, 8'h00,
                                          8'h00, 8'h19, 8'hd6, 8'h68};
    localparam logic [31:0] PIN32 [2] = '{32'h00000000, 32'h0019d668};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   start, rdy, rq, done, busy, hdr_valid, hdr_ack, dig_valid, nonce_inc;
    logic [7:0]   din8, dout8;
    logic [31:0]  din32, dout32;
    logic [639:0] hdr_data [2];
    logic [255:0] dig_data [2];

    logic [639:0] exp_hdr [2];
    logic [255:0] exp_dig [2];
    int           rd_idx [2];
    int           rq_rises [2];
    logic [1:0]   rq_prev;
    bit           cmp_en;
    int           checks;
    int           failures;

    hdr_link_ctrl #(.BUS_W(8), .HDR_BYTES(80), .DIG_BYTES(32), .SYNC_STAGES(SYNC)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .rdy_i(rdy[0]), .din_i(din8),
        .dout_o(dout8), .rq_o(rq[0]), .done_o(done[0]), .busy_o(busy[0]),
        .hdr_data_o(hdr_data[0]), .hdr_valid_o(hdr_valid[0]), .hdr_ack_i(hdr_ack[0]),
        .dig_data_i(dig_data[0]), .dig_valid_i(dig_valid[0]), .nonce_inc_i(nonce_inc[0])
    );

    hdr_link_ctrl #(.BUS_W(32), .HDR_BYTES(80), .DIG_BYTES(32), .SYNC_STAGES(SYNC)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .rdy_i(rdy[1]), .din_i(din32),
        .dout_o(dout32), .rq_o(rq[1]), .done_o(done[1]), .busy_o(busy[1]),
        .hdr_data_o(hdr_data[1]), .hdr_valid_o(hdr_valid[1]), .hdr_ack_i(hdr_ack[1]),
        .dig_data_i(dig_data[1]), .dig_valid_i(dig_valid[1]), .nonce_inc_i(nonce_inc[1])
    );

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dout_of(input int u);
        return (u == 0) ? {24'd0, dout8} : dout32;
    endfunction

    // Expected digest beat: the next unread BUS_W slice, MSB first.
    function automatic logic [31:0] exp_beat(input int u);
        int           bw;
        logic [255:0] t;
        bw = (u == 0) ? 8 : 32;
        t  = exp_dig[u] << (rd_idx[u] * bw);
        return t[255:224] >> (32 - bw);
    endfunction

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int u = 0; u < 2; u++) begin
                if (rq[u] && !rq_prev[u]) rq_rises[u]++;
                rq_prev[u] = rq[u];
                if (!busy[u]) begin
                    check("idle_outs", {rq[u], done[u], hdr_valid[u]}, 3'b000);
                    check("idle_hdr", hdr_data[u], exp_hdr[u]);
                end
                if (hdr_valid[u]) begin
                    check("valid_outs", {busy[u], rq[u], done[u]}, 3'b100);
                    check("valid_hdr", hdr_data[u], exp_hdr[u]);
                end
                if (done[u] && rq[u]) check("dout_model", dout_of(u), exp_beat(u));
            end
        end
    end

    task automatic wait_rq(input int u);
        int n = 0;
        while (rq[u] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rq_wait", rq[u], 1'b1);
    endtask

    // One handshake beat: rq must hold for SYNC cycles after rdy rises, then drop.
    task automatic do_beat(input int u, input logic [31:0] d, input bit unload);
        wait_rq(u);
        if (u == 0) din8 = d[7:0];
        else din32 = d;
        rdy[u] = 1'b1;
        repeat (SYNC) begin
            @(posedge clk); #1;
        end
        check("rq_hold", rq[u], 1'b1);
        @(posedge clk); #1;
        check("rq_drop", rq[u], 1'b0);
        if (unload) rd_idx[u]++;
        rdy[u] = 1'b0;
    endtask

    task automatic load_hdr(input int u, input logic [639:0] h, input int nbeats);
        int           bw;
        logic [639:0] t;
        bw = (u == 0) ? 8 : 32;
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        exp_hdr[u]  = h;
        rq_rises[u] = 0;
        for (int k = 0; k < nbeats; k++) begin
            t = h << (k * bw);
            do_beat(u, t[639:608] >> (32 - bw), 1'b0);
            if (u == 0 && nbeats == 80 && (k == 10 || k == 50)) begin
                start[u] = 1'b1;
                @(posedge clk); #1;
                start[u] = 1'b0;
            end
        end
    endtask

    task automatic ack_hdr(input int u, input int delay, input bit early);
        for (int i = 0; i < delay; i++) begin
            if (early && i == 10) begin
                dig_data[u]  = {32{8'hAA}};
                dig_valid[u] = 1'b1;
            end
            if (early && i == 20) rdy[u] = 1'b1;
            if (early && i == 25) rdy[u] = 1'b0;
            @(posedge clk); #1;
            dig_valid[u] = 1'b0;
            check("hdr_valid_held", hdr_valid[u], 1'b1);
        end
        hdr_ack[u] = 1'b1;
        @(posedge clk); #1;
        hdr_ack[u] = 1'b0;
        check("hdr_valid_clear", {busy[u], hdr_valid[u]}, 2'b10);
    endtask

    task automatic feed_dig(input int u, input logic [255:0] d);
        repeat (5) begin
            @(posedge clk); #1;
            check("wait_dig", {done[u], rq[u], busy[u]}, 3'b001);
        end
        dig_data[u]  = d;
        dig_valid[u] = 1'b1;
        exp_dig[u]   = d;
        rd_idx[u]    = 0;
        @(posedge clk); #1;
        dig_valid[u] = 1'b0;
        check("unload_entry", {done[u], rq[u], busy[u]}, 3'b111);
    endtask

    task automatic unload(input int u, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            wait_rq(u);
            if (u == 0 && k < 8) check("dout_pin8", dout_of(u), {24'd0, PIN8[k]});
            if (u == 0 && k == 31) check("dout_last8", dout_of(u), 32'h6f);
            if (u == 1 && k < 2) check("dout_pin32", dout_of(u), PIN32[k]);
            if (u == 1 && k == 7) check("dout_last32", dout_of(u), 32'h0a8ce26f);
            do_beat(u, 32'd0, 1'b1);
        end
        check("unload_end", {done[u], rq[u], busy[u]}, 3'b000);
    endtask

    task automatic full_load(input int u, input logic [639:0] h, input int nbeats);
        load_hdr(u, h, nbeats);
        check("load_valid", {hdr_valid[u], busy[u]}, 2'b11);
        check("rq_rises", rq_rises[u], nbeats);
    endtask

    task automatic finish_flow(input int u, input int nbeats);
        ack_hdr(u, 3, 1'b0);
        feed_dig(u, DIGEST);
        unload(u, nbeats);
    endtask

    task automatic nonce_try(input int u);
        logic [639:0] h;
        logic [31:0]  n;
        h = exp_hdr[u];
        nonce_inc[u] = 1'b1;
        @(posedge clk); #1;
        nonce_inc[u] = 1'b0;
`ifdef BITCOIN_NONCE_SWEEP_EN
        n = {h[7:0], h[15:8], h[23:16], h[31:24]} + 32'd1;
        h[31:0] = {n[7:0], n[15:8], n[23:16], n[31:24]};
        exp_hdr[u] = h;
        check("nonce_enter", {busy[u], hdr_valid[u], rq[u]}, 3'b110);
`else
        check("nonce_off", {busy[u], hdr_valid[u], rq[u]}, 3'b000);
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cmp_en = 1'b0; rq_prev = '0;
        rst_n = 1'b0; start = '0; rdy = '0; hdr_ack = '0; dig_valid = '0; nonce_inc = '0;
        din8 = '0; din32 = '0;
        for (int u = 0; u < 2; u++) begin
            dig_data[u] = '0; exp_hdr[u] = '0; exp_dig[u] = '0; rd_idx[u] = 0; rq_rises[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_outs", {rq[u], done[u], busy[u], hdr_valid[u]}, 4'b0000);
            check("rst_dout", dout_of(u), 32'd0);
            check("rst_hdr", hdr_data[u], 640'd0);
        end
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Strobe with no request outstanding.
        rdy[0] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("stray_rdy", {busy[0], rq[0]}, 2'b00);
        rdy[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Abort half-way through a load.
        load_hdr(0, GENESIS, 40);
        check("partial_load", {busy[0], hdr_valid[0]}, 2'b10);
        rst_n = 1'b0;
        exp_hdr[0] = '0;
        #1;
        check("abort_outs", {rq[0], done[0], hdr_valid[0], busy[0]}, 4'b0000);
        check("abort_hdr", hdr_data[0], 640'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Genesis load, delayed ack with an early digest, then digest unload.
        full_load(0, GENESIS, 80);
        check("hdr_first_byte", hdr_data[0][639:632], 8'h01);
        check("hdr_last_byte", hdr_data[0][7:0], 8'h7C);
        ack_hdr(0, 50, 1'b1);
        feed_dig(0, DIGEST);
        unload(0, 32);

        // Nonce sweep from the genesis header.
        nonce_try(0);
`ifdef BITCOIN_NONCE_SWEEP_EN
        check("nonce_bytes", hdr_data[0][31:0], 32'h1EAC2B7C);
        finish_flow(0, 32);
`else
        check("nonce_bytes", hdr_data[0][31:0], 32'h1DAC2B7C);
`endif

        // Nonce wrap.
        full_load(0, WRAPHDR, 80);
        finish_flow(0, 32);
        nonce_try(0);
`ifdef BITCOIN_NONCE_SWEEP_EN
        check("nonce_wrap", hdr_data[0][31:0], 32'h00000000);
        finish_flow(0, 32);
`else
        check("nonce_wrap", hdr_data[0][31:0], 32'hFFFFFFFF);
`endif

        // 32-bit bus.
        full_load(1, GENESIS, 20);
        check("hdr32_first_word", hdr_data[1][639:608], 32'h01000000);
        finish_flow(1, 8);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
